mdr_mem_ctrl: RTL and testbench
===============================

Name: mdr_mem_ctrl

Overview:
- Memory-side data stage that pairs with the MAR/RAM block.
- Owns the 32-bit MDR and sequences every RAM access.
- Takes single-cycle read/write requests from the control unit, drives the RAM read/write strobes for a programmable number of cycles, captures read data into MDR, and returns a one-cycle done pulse.
- MAR must already hold the address when a request is issued.

Parameters:
WAIT_CYCLES, 1, extra cycles a strobe is held beyond the first; legal 0..15
DATA_W, 32, MDR / data bus width

Ports:
clk  in  1  system clock, all state updates on rising edge
clr  in  1  synchronous active-high reset
BusMuxOut  in  DATA_W  CPU bus value, loaded into MDR on MDRin
MDRin  in  1  load MDR from BusMuxOut (honoured only in IDLE)
req_read  in  1  start memory read (sampled in IDLE only)
req_write  in  1  start memory write of current MDR (sampled in IDLE only)
Mdatain  in  DATA_W  RAM read data
read  out  1  RAM read strobe
write  out  1  RAM write strobe
MDRMuxIn  out  DATA_W  write data to RAM; always equals mdr_q
mdr_q  out  DATA_W  MDR contents, to bus mux
busy  out  1  high in ACCESS and DONE
done  out  1  one-cycle completion pulse
proto_err  out  1  one-cycle pulse on illegal request

Behaviour:
- Reset (clr=1 at a rising edge): state=IDLE, count=0, mdr_q=0, and read, write, busy, done, proto_err all 0 from the next cycle. Reset overrides everything, including mid-access; an aborted write may or may not have committed in RAM. The bench does not check that.
- States: IDLE, ACCESS, DONE. Registered outputs decode state; no combinational path from req_* to the strobes.
- IDLE:
  - MDRin=1 -> mdr_q<=BusMuxOut.
  - Exactly one of req_read/req_write =1 -> op<=that request, count<=WAIT_CYCLES, state<=ACCESS.
  - Both =1 -> no access, stay IDLE, proto_err=1 next cycle. MDRin in the same cycle is still honoured.
- MDRin together with req_write in IDLE: MDR loads first, and the write stores the newly loaded value.
- ACCESS:
  - read=1 (op=read) or write=1 (op=write) for exactly WAIT_CYCLES+1 consecutive cycles.
  - count decrements each cycle. When count==0 -> state<=DONE.
  - For a read, on that same edge mdr_q<=Mdatain.
- DONE: done=1, busy=1, strobes 0 for one cycle, then IDLE.
- Latency: request sampled at edge E0, strobe high in cycles 1..WAIT_CYCLES+1, done high in cycle WAIT_CYCLES+2. Next request is accepted at the edge ending the DONE cycle + 1, i.e. in IDLE.
- req_* and MDRin while busy are ignored: no queuing, no error, MDR unchanged except for read capture.
- MDRMuxIn is stable for the whole write strobe, because MDR cannot change in ACCESS.
- Count width is 4 bits; WAIT_CYCLES outside 0..15 is a compile-time error (generate-time check).

Test Plan:
1. Reset: drive clr=1 for 2 cycles with req_read=1 and MDRin=1, BusMuxOut=0xDEADBEEF -> mdr_q=0, read=write=busy=done=0 throughout.
2. Read, WAIT_CYCLES=1: RAM[0x85]=0x0000000F, MAR=0x85, req_read pulse -> read high exactly cycles 1-2, done in cycle 3, mdr_q=0x0000000F from cycle 3.
3. Load+write same cycle: MDRin=1, BusMuxOut=0x00000085, req_write=1, MAR=0x90 -> write high 2 cycles with MDRMuxIn=0x85, then RAM[0x90]=0x85 and done pulse.
4. WAIT_CYCLES=0 read of RAM[0x44]=0xFFFFFFF0 -> read high 1 cycle, done in cycle 2, mdr_q=0xFFFFFFF0.
5. Both requests high in IDLE -> proto_err one cycle, read=write=0, busy=0.
6. Mid-access: req_write during ACCESS ignored; MDRin with 0x1234 during a read is ignored, and mdr_q ends as RAM data. clr asserted in ACCESS cycle 1 -> IDLE next cycle, strobe low, mdr_q=0, no done.

Source files
------------

// File: rtl/mdr_mem_ctrl.sv
// mdr_mem_ctrl
// Memory-side data stage paired with the MAR/RAM block. Owns the MDR and
// sequences every RAM access: a single-cycle read or write request from the
// control unit holds the matching RAM strobe for WAIT_CYCLES+1 cycles. A read
// captures RAM data into the MDR. A one-cycle done pulse then follows.
// MAR must already hold the address when a request is issued.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   clr        synchronous active-high reset
//   BusMuxOut  CPU bus value, loaded into the MDR when MDRin is high in IDLE
//   MDRin      load MDR from BusMuxOut (honoured only in IDLE)
//   req_read   start a memory read (sampled only in IDLE)
//   req_write  start a memory write of the MDR (sampled only in IDLE)
//   Mdatain    RAM read data
//   read       RAM read strobe
//   write      RAM write strobe
//   MDRMuxIn   write data to RAM, always the MDR contents
//   mdr_q      MDR contents, to the bus mux
//   busy       high while an access is in progress (ACCESS and DONE)
//   done       one-cycle completion pulse
//   proto_err  one-cycle pulse when both requests arrive together in IDLE

module mdr_mem_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MDRin,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [DATA_W-1:0] Mdatain,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] MDRMuxIn,
  output logic [DATA_W-1:0] mdr_q,
  output logic              busy,
  output logic              done,
  output logic              proto_err
);

  // The wait counter is 4 bits wide, so larger settings cannot be represented.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("mdr_mem_ctrl: WAIT_CYCLES must be in the range 0..15");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic              op_q, op_d;        // 1 = write, 0 = read
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] mdr_d;

  // State register. Reset wins over everything, including an access in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      op_q    <= 1'b0;
      perr_q  <= 1'b0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      perr_q  <= perr_d;
      mdr_q   <= mdr_d;
    end
  end

  // Next-state logic. A load with MDRin and a write request in the same IDLE
  // cycle both take effect: the MDR loads on that edge. The write strobe only
  // starts in the following cycle, so it stores the newly loaded value.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    perr_d  = 1'b0;
    mdr_d   = mdr_q;

    unique case (state_q)
      IDLE: begin
        if (MDRin) begin
          mdr_d = BusMuxOut;
        end
        if (req_read && req_write) begin
          perr_d = 1'b1;
        end else if (req_read || req_write) begin
          op_d    = req_write;
          count_d = 4'(WAIT_CYCLES);
          state_d = ACCESS;
        end
      end

      // Count reaching zero marks the last strobe cycle. Read data is taken
      // on that same edge, while RAM is still being strobed.
      ACCESS: begin
        if (count_q == 4'd0) begin
          state_d = DONE;
          if (!op_q) begin
            mdr_d = Mdatain;
          end
        end else begin
          count_d = count_q - 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only, so the request inputs have no
  // combinational path to the RAM strobes.
  assign read      = (state_q == ACCESS) && !op_q;
  assign write     = (state_q == ACCESS) &&  op_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign proto_err = perr_q;
  assign MDRMuxIn  = mdr_q;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// tb_mdr_mem_ctrl
// Drives two controller instances side by side, one with WAIT_CYCLES=0 and
// one with WAIT_CYCLES=1. Each instance has its own small RAM model. The two
// RAMs share one MAR register kept in the bench. Expected MDR/RAM results are
// queued when a request is issued. They are compared when done pulses.

module tb_mdr_mem_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] busIn;
  logic        mdrIn;
  logic        reqRd;
  logic        reqWr;
  logic [7:0]  mar;

  logic [1:0]  rdS;
  logic [1:0]  wrS;
  logic [1:0]  busyS;
  logic [1:0]  doneS;
  logic [1:0]  perrS;
  logic [31:0] mdrS  [2];
  logic [31:0] muxS  [2];
  logic [31:0] mdatS [2];
  logic [31:0] ram   [2][256];

  logic [31:0] sbQ0 [$];
  logic [31:0] sbQ1 [$];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // RAM models: asynchronous read, and a write on the clock edge while the
  // write strobe is high.
  assign mdatS[0] = ram[0][mar];
  assign mdatS[1] = ram[1][mar];

  always @(posedge clk) begin
    if (wrS[0] === 1'b1) ram[0][mar] <= muxS[0];
    if (wrS[1] === 1'b1) ram[1][mar] <= muxS[1];
  end

  mdr_mem_ctrl #(.WAIT_CYCLES(0), .DATA_W(32)) dut0 (
    .clk(clk), .clr(clr), .BusMuxOut(busIn), .MDRin(mdrIn),
    .req_read(reqRd), .req_write(reqWr), .Mdatain(mdatS[0]),
    .read(rdS[0]), .write(wrS[0]), .MDRMuxIn(muxS[0]), .mdr_q(mdrS[0]),
    .busy(busyS[0]), .done(doneS[0]), .proto_err(perrS[0])
  );

  mdr_mem_ctrl #(.WAIT_CYCLES(1), .DATA_W(32)) dut1 (
    .clk(clk), .clr(clr), .BusMuxOut(busIn), .MDRin(mdrIn),
    .req_read(reqRd), .req_write(reqWr), .Mdatain(mdatS[1]),
    .read(rdS[1]), .write(wrS[1]), .MDRMuxIn(muxS[1]), .mdr_q(mdrS[1]),
    .busy(busyS[1]), .done(doneS[1]), .proto_err(perrS[1])
  );

  // One comparison: count it, and report the observed and expected values on
  // a miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      $error("[TB] %s miscompared", tag);
    end
  endtask

  // Hold the request inputs for exactly one rising edge.
  // The bench then returns 1 time unit after that edge, in cycle 1.
  task automatic applyStimulus(input logic rr, input logic rw, input logic ld,
                               input logic [31:0] bus);
    reqRd = rr;
    reqWr = rw;
    mdrIn = ld;
    busIn = bus;
    @(posedge clk);
    #1;
    reqRd = 1'b0;
    reqWr = 1'b0;
    mdrIn = 1'b0;
  endtask

  // Walk cycles 1..4 after a request. Instance d has WAIT_CYCLES=d.
  // Its strobe is expected in cycles 1..d+1, and done/queue check in cycle d+2.
  // With disturb set, a write request and an MDR load are driven during cycle
  // 1. The controller must ignore both.
  task automatic runAccess(input string tag, input bit isWrite,
                           input logic [31:0] wrVal, input bit disturb);
    bit          expStrobe;
    bit          expDone;
    bit          expBusy;
    logic [31:0] expVal;
    logic [31:0] obsVal;
    for (int c = 1; c <= 4; c++) begin
      for (int d = 0; d < 2; d++) begin
        expStrobe = (c <= d + 1);
        expDone   = (c == d + 2);
        expBusy   = (c <= d + 2);
        checkOutput($sformatf("%s_read_d%0d_c%0d", tag, d, c),
                    {31'b0, rdS[d]}, {31'b0, expStrobe && !isWrite});
        checkOutput($sformatf("%s_write_d%0d_c%0d", tag, d, c),
                    {31'b0, wrS[d]}, {31'b0, expStrobe && isWrite});
        checkOutput($sformatf("%s_done_d%0d_c%0d", tag, d, c),
                    {31'b0, doneS[d]}, {31'b0, expDone});
        checkOutput($sformatf("%s_busy_d%0d_c%0d", tag, d, c),
                    {31'b0, busyS[d]}, {31'b0, expBusy});
        if (isWrite && expStrobe) begin
          checkOutput($sformatf("%s_mux_d%0d_c%0d", tag, d, c), muxS[d], wrVal);
        end
        if (expDone) begin
          if ((d == 0 && sbQ0.size() == 0) || (d == 1 && sbQ1.size() == 0)) begin
            checkOutput($sformatf("%s_sbUnderflow_d%0d", tag, d), 32'd1, 32'd0);
          end else begin
            expVal = (d == 0) ? sbQ0.pop_front() : sbQ1.pop_front();
            obsVal = isWrite ? ram[d][mar] : mdrS[d];
            checkOutput($sformatf("%s_result_d%0d", tag, d), obsVal, expVal);
          end
        end
      end
      if (disturb && c == 1) begin
        reqWr = 1'b1;
        mdrIn = 1'b1;
        busIn = 32'h0000_1234;
      end else if (disturb && c == 2) begin
        reqWr = 1'b0;
        mdrIn = 1'b0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    clr   = 1'b0;
    busIn = '0;
    mdrIn = 1'b0;
    reqRd = 1'b0;
    reqWr = 1'b0;
    mar   = 8'h00;
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 256; a++) ram[d][a] = 32'h0;
      ram[d][8'h85] = 32'h0000_000F;
      ram[d][8'h44] = 32'hFFFF_FFF0;
      ram[d][8'h30] = 32'hCAFE_0001;
    end

    // Reset must dominate a simultaneous read request and MDR load.
    $display("[TB] reset with competing requests");
    clr   = 1'b1;
    reqRd = 1'b1;
    mdrIn = 1'b1;
    busIn = 32'hDEAD_BEEF;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("rst_mdr_d%0d_c%0d", d, c), mdrS[d], 32'h0);
        checkOutput($sformatf("rst_strobes_d%0d_c%0d", d, c),
                    {30'b0, rdS[d], wrS[d]}, 32'h0);
        checkOutput($sformatf("rst_busydone_d%0d_c%0d", d, c),
                    {30'b0, busyS[d], doneS[d]}, 32'h0);
      end
    end
    clr   = 1'b0;
    reqRd = 1'b0;
    mdrIn = 1'b0;
    @(posedge clk);
    #1;

    // Read RAM[0x85].
    $display("[TB] read 0x85");
    mar = 8'h85;
    sbQ0.push_back(32'h0000_000F);
    sbQ1.push_back(32'h0000_000F);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    runAccess("rd85", 1'b0, 32'h0, 1'b0);

    // MDR load and write in the same cycle: the new value is written.
    $display("[TB] load+write to 0x90");
    mar = 8'h90;
    sbQ0.push_back(32'h0000_0085);
    sbQ1.push_back(32'h0000_0085);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0085);
    runAccess("wr90", 1'b1, 32'h0000_0085, 1'b0);

    // Read RAM[0x44].
    $display("[TB] read 0x44");
    mar = 8'h44;
    sbQ0.push_back(32'hFFFF_FFF0);
    sbQ1.push_back(32'hFFFF_FFF0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    runAccess("rd44", 1'b0, 32'h0, 1'b0);

    // Both requests together: protocol error, no access, MDR load still taken.
    $display("[TB] simultaneous requests");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("perr_pulse_d%0d", d), {31'b0, perrS[d]}, 32'd1);
      checkOutput($sformatf("perr_strobes_d%0d", d),
                  {30'b0, rdS[d], wrS[d]}, 32'h0);
      checkOutput($sformatf("perr_busy_d%0d", d), {31'b0, busyS[d]}, 32'd0);
      checkOutput($sformatf("perr_mdr_d%0d", d), mdrS[d], 32'hA5A5_A5A5);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("perr_clear_d%0d", d), {31'b0, perrS[d]}, 32'd0);
      checkOutput($sformatf("perr_idle_d%0d", d), {31'b0, busyS[d]}, 32'd0);
    end

    // Requests and MDR loads during an access are ignored.
    // The read still lands RAM data in the MDR.
    $display("[TB] disturbed read 0x30");
    mar = 8'h30;
    sbQ0.push_back(32'hCAFE_0001);
    sbQ1.push_back(32'hCAFE_0001);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    runAccess("rd30", 1'b0, 32'h0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rd30_hold_d%0d", d), mdrS[d], 32'hCAFE_0001);
      checkOutput($sformatf("rd30_idle_d%0d", d), {31'b0, busyS[d]}, 32'd0);
    end

    // Reset in the first access cycle aborts the read without a done pulse.
    $display("[TB] reset mid-access");
    mar = 8'h85;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    for (int c = 0; c < 2; c++) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("abort_read_d%0d_c%0d", d, c), {31'b0, rdS[d]}, 32'd0);
        checkOutput($sformatf("abort_busy_d%0d_c%0d", d, c), {31'b0, busyS[d]}, 32'd0);
        checkOutput($sformatf("abort_done_d%0d_c%0d", d, c), {31'b0, doneS[d]}, 32'd0);
        checkOutput($sformatf("abort_mdr_d%0d_c%0d", d, c), mdrS[d], 32'h0);
      end
      @(posedge clk);
      #1;
    end

    checkOutput("sb_empty", 32'(sbQ0.size() + sbQ1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
